mem_wb_latch: RTL

//  Pipeline register between the memory stage (data cache) and writeback.
//  - Advances one instruction per cycle when memory completes and the pipeline is not externally frozen.
//  - Inserts a bubble while a cache access is still pending.
//  - Captures a one-cycle cache Done/data pulse that lands while the pipeline is frozen, so the load result is

---
 rtl/mem_wb_latch_pkg.sv | 25 ++
 rtl/mem_wb_latch_dff_en.sv | 19 +
 rtl/mem_wb_latch.sv | 95 +++++++++
 3 files changed

// File: rtl/mem_wb_latch_pkg.sv
// Shared definitions for the MEM/WB pipeline register: capture FSM encodings,
// default widths and the capture FSM next-state helper.
package mem_wb_latch_pkg;

   localparam int DATA_W_DEF = 16;
   localparam int REG_W_DEF  = 3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_CAPT = 1'b1;

   // A done pulse during a freeze is parked in CAPT until the slot advances.
   function automatic logic [0:0] capt_next(input logic [0:0] st,
                                            input logic       done,
                                            input logic       stall_ext,
                                            input logic       advance);
      logic [0:0] nxt;
      nxt = st;
      if (st == ST_IDLE && done && stall_ext)
         nxt = ST_CAPT;
      else if (st == ST_CAPT && advance)
         nxt = ST_IDLE;
      return nxt;
   endfunction

endpackage

// File: rtl/mem_wb_latch_dff_en.sv
// Enabled register bank with asynchronous active-low clear.
module dff_en #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/mem_wb_latch.sv
// MEM/WB pipeline register: advances on memory completion, bubbles while the
// cache is pending, and parks a cache result that lands during a global freeze.
module mem_wb_latch
   import mem_wb_latch_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_W  = REG_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              valid_in,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic              mem_to_reg,
   input  logic              reg_write,
   input  logic [REG_W-1:0]  wb_reg_in,
   input  logic [DATA_W-1:0] alu_result,
   input  logic [DATA_W-1:0] read_data,
   input  logic              done,
   input  logic              err_mem,
   input  logic              halt_in,
   input  logic              stall_ext,
   output logic              stall_out,
   output logic              mem_captured,
   output logic              wb_valid,
   output logic [DATA_W-1:0] wb_data,
   output logic [REG_W-1:0]  wb_reg,
   output logic              wb_reg_write,
   output logic              wb_halt,
   output logic              wb_err
);

   localparam int PAY_W = DATA_W + REG_W + 1;

   logic [0:0]        state_reg;
   logic [0:0]        state_next;
   logic              halted_reg;
   logic [DATA_W-1:0] buf_reg;
   logic              captured;
   logic              mem_op;
   logic              complete;
   logic              advance;
   logic              capture_en;
   logic              halt_en;
   logic [DATA_W-1:0] wb_data_next;
   logic [1:0]        ctl_next;
   logic [1:0]        ctl_reg;
   logic [PAY_W-1:0]  pay_next;
   logic [PAY_W-1:0]  pay_reg;

   assign captured   = (state_reg == ST_CAPT);
   assign mem_op     = valid_in & (mem_read | mem_write);
   assign complete   = ~mem_op | done | captured;
   assign advance    = complete & ~stall_ext & ~halted_reg;
   assign capture_en = ~captured & done & stall_ext;
   assign halt_en    = advance & valid_in & halt_in;
   assign state_next = capt_next(state_reg, done, stall_ext, advance);

   assign wb_data_next = mem_to_reg ? (captured ? buf_reg : read_data) : alu_result;

   // Valid/write-enable update whenever not frozen; they clear on any non-advance
   // cycle, which covers both the pending-cache bubble and the halted state.
   assign ctl_next = {advance & valid_in, advance & valid_in & reg_write};
   assign pay_next = {wb_data_next, wb_reg_in, valid_in & err_mem};

   dff_en #(.W(1)) u_state (
      .clk(clk), .rst_n(rst_n), .en(1'b1), .d(state_next), .q(state_reg)
   );

   dff_en #(.W(1)) u_halted (
      .clk(clk), .rst_n(rst_n), .en(halt_en), .d(1'b1), .q(halted_reg)
   );

   dff_en #(.W(DATA_W)) u_buf (
      .clk(clk), .rst_n(rst_n), .en(capture_en), .d(read_data), .q(buf_reg)
   );

   dff_en #(.W(2)) u_wb_ctl (
      .clk(clk), .rst_n(rst_n), .en(~stall_ext), .d(ctl_next), .q(ctl_reg)
   );

   dff_en #(.W(PAY_W)) u_wb_pay (
      .clk(clk), .rst_n(rst_n), .en(advance), .d(pay_next), .q(pay_reg)
   );

   assign stall_out    = ~advance;
   assign mem_captured = captured;
   assign wb_valid     = ctl_reg[1];
   assign wb_reg_write = ctl_reg[0];
   assign wb_data      = pay_reg[PAY_W-1 -: DATA_W];
   assign wb_reg       = pay_reg[REG_W:1];
   assign wb_err       = pay_reg[0];
   assign wb_halt      = halted_reg;

endmodule
